// File: rtl/lock_keypad_frontend.sv
`default_nettype none
// ============================================================================
// Module   : lock_keypad_frontend
// Purpose  : Two-button synchronizer/debouncer, one-event-per-press FSM and
//            idle-timeout pulse feeding the lock sequence detector.
// Revision : 1.0  initial release
// ============================================================================
module lock_keypad_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int IDLE_TIMEOUT    = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn0_raw,
    input  logic btn1_raw,
    output logic b0,
    output logic b1,
    output logic key_valid,
    output logic entry_clear,
    output logic busy
);

    localparam int                c_DB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int                c_TO_W    = $clog2(IDLE_TIMEOUT) + 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(IDLE_TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HELD = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    logic [1:0] w_raw;
    logic [1:0] w_deb;

    assign w_raw = {btn1_raw, btn0_raw};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_deb
            logic              r_s1;
            logic              r_s2;
            logic              r_deb;
            logic [c_DB_W-1:0] r_cnt;

            // Level flips on the DEBOUNCE_CYCLES-th consecutive disagreement.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1  <= 1'b0;
                    r_s2  <= 1'b0;
                    r_deb <= 1'b0;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_DB_LAST) begin
                        r_deb <= ~r_deb;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_deb[gi] = r_deb;
        end
    endgenerate

    logic [1:0] r_state;
    logic [1:0] w_next;
    logic       w_ev0;
    logic       w_ev1;
    logic       w_evt;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_deb == 2'b11)      w_next = S_WAIT;
                else if (w_deb != 2'b00) w_next = S_HELD;
            end
            S_HELD: begin
                if (w_deb == 2'b00)      w_next = S_IDLE;
                else if (w_deb == 2'b11) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_deb == 2'b00)      w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ev0 = (r_state == S_IDLE) && (w_deb == 2'b01);
        w_ev1 = (r_state == S_IDLE) && (w_deb == 2'b10);
        w_evt = w_ev0 | w_ev1;
    end

    logic r_b0;
    logic r_b1;
    logic r_kv;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_b0 <= 1'b0;
            r_b1 <= 1'b0;
            r_kv <= 1'b0;
        end else begin
            r_b0 <= w_ev0;
            r_b1 <= w_ev1;
            r_kv <= w_evt;
        end
    end

    logic              r_armed;
    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_clr;

    // Armed from the same edge that registers the event; a new event beats an
    // expiring count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed  <= 1'b0;
            r_to_cnt <= '0;
            r_clr    <= 1'b0;
        end else begin
            r_clr <= 1'b0;
            if (w_evt) begin
                r_armed  <= 1'b1;
                r_to_cnt <= '0;
            end else if (r_armed) begin
                if (r_to_cnt == c_TO_LAST) begin
                    r_clr    <= 1'b1;
                    r_armed  <= 1'b0;
                    r_to_cnt <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    assign b0          = r_b0;
    assign b1          = r_b1;
    assign key_valid   = r_kv;
    assign entry_clear = r_clr;
    assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_lock_keypad_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_keypad_frontend
// Purpose  : Directed self-checking bench for lock_keypad_frontend (D=4, T=20).
// Revision : 1.0  initial release
// ============================================================================
module tb_lock_keypad_frontend;

    logic clk;
    logic reset;
    logic btn0_raw;
    logic btn1_raw;
    logic b0;
    logic b1;
    logic key_valid;
    logic entry_clear;
    logic busy;

    int n_checks = 0;
    int n_errors = 0;
    int e        = 0;
    int ev_cnt   = 0;
    int b0_cnt   = 0;
    int b1_cnt   = 0;
    int both_cnt = 0;
    int clr_cnt  = 0;

    lock_keypad_frontend #(
        .DEBOUNCE_CYCLES (4),
        .IDLE_TIMEOUT    (20)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .btn0_raw    (btn0_raw),
        .btn1_raw    (btn1_raw),
        .b0          (b0),
        .b1          (b1),
        .key_valid   (key_valid),
        .entry_clear (entry_clear),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample just after it and tally observed pulses.
    task automatic tick();
        @(posedge clk);
        #1;
        e++;
        if (key_valid)   ev_cnt++;
        if (b0)          b0_cnt++;
        if (b1)          b1_cnt++;
        if (b0 && b1)    both_cnt++;
        if (entry_clear) clr_cnt++;
    endtask

    task automatic run_to(input int target);
        while (e < target) tick();
    endtask

    task automatic clear_counts();
        ev_cnt   = 0;
        b0_cnt   = 0;
        b1_cnt   = 0;
        both_cnt = 0;
        clr_cnt  = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        clear_counts();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int m;
        int r;
        int total;
        reset    = 1'b1;
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        tick();
        check("rst_b0",  b0, 0);
        check("rst_b1",  b1, 0);
        check("rst_kv",  key_valid, 0);
        check("rst_clr", entry_clear, 0);
        check("rst_busy", busy, 0);
        do_reset();

        // Clean press on button 1
        btn1_raw = 1'b1;
        n = e + 1;
        run_to(n + 5);
        check("clean_kv_early", key_valid, 0);
        check("clean_busy_early", busy, 0);
        run_to(n + 6);
        check("clean_kv", key_valid, 1);
        check("clean_b0", b0, 0);
        check("clean_b1", b1, 1);
        check("clean_busy", busy, 1);
        run_to(n + 7);
        check("clean_kv_drop", key_valid, 0);
        run_to(n + 29);
        btn1_raw = 1'b0;
        r = n + 30;
        run_to(r + 5);
        check("clean_busy_rel5", busy, 1);
        run_to(r + 6);
        check("clean_busy_rel6", busy, 0);
        run_to(r + 12);
        check("clean_ev_cnt", ev_cnt, 1);
        check("clean_b1_cnt", b1_cnt, 1);
        check("clean_b0_cnt", b0_cnt, 0);

        // Bounce on button 0: pulses of 1..3 cycles, then a steady press
        do_reset();
        total = 0;
        for (int k = 0; total < 30; k++) begin
            btn0_raw = (k % 2 == 0);
            repeat ((k % 3) + 1) tick();
            total += (k % 3) + 1;
        end
        btn0_raw = 1'b0;
        tick();
        tick();
        check("bounce_no_ev", ev_cnt, 0);
        btn0_raw = 1'b1;
        n = e + 1;
        run_to(n + 5);
        check("bounce_kv_early", key_valid, 0);
        run_to(n + 6);
        check("bounce_kv", key_valid, 1);
        check("bounce_b0", b0, 1);
        check("bounce_b1", b1, 0);
        btn0_raw = 1'b0;
        repeat (12) tick();
        check("bounce_ev_cnt", ev_cnt, 1);
        check("bounce_idle", busy, 0);

        // Simultaneous press
        do_reset();
        btn0_raw = 1'b1;
        btn1_raw = 1'b1;
        n = e + 1;
        run_to(n + 6);
        check("simul_busy", busy, 1);
        run_to(n + 19);
        check("simul_busy_hold", busy, 1);
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        repeat (12) tick();
        check("simul_no_ev", ev_cnt, 0);
        check("simul_idle", busy, 0);

        // Overlap: button 0 first, button 1 ten cycles later
        do_reset();
        btn0_raw = 1'b1;
        n = e + 1;
        run_to(n + 9);
        btn1_raw = 1'b1;
        run_to(n + 19);
        btn0_raw = 1'b0;
        btn1_raw = 1'b0;
        repeat (12) tick();
        check("overlap_b0_cnt", b0_cnt, 1);
        check("overlap_b1_cnt", b1_cnt, 0);
        check("overlap_idle", busy, 0);
        check("never_both", both_cnt, 0);

        // Timeout after a single press
        do_reset();
        btn0_raw = 1'b1;
        n = e + 1;
        m = n + 6;
        run_to(n + 4);
        btn0_raw = 1'b0;
        run_to(m);
        check("to_kv", key_valid, 1);
        run_to(m + 19);
        check("to_clr_early", entry_clear, 0);
        run_to(m + 20);
        check("to_clr", entry_clear, 1);
        run_to(m + 21);
        check("to_clr_drop", entry_clear, 0);
        run_to(m + 80);
        check("to_clr_once", clr_cnt, 1);

        // Second press 15 cycles after the first event restarts the count
        do_reset();
        btn0_raw = 1'b1;
        n = e + 1;
        m = n + 6;
        run_to(n + 4);
        btn0_raw = 1'b0;
        run_to(n + 14);
        btn0_raw = 1'b1;
        run_to(n + 19);
        btn0_raw = 1'b0;
        run_to(m + 15);
        check("re_kv2", key_valid, 1);
        run_to(m + 20);
        check("re_clr_supp", entry_clear, 0);
        run_to(m + 34);
        check("re_clr_cnt_mid", clr_cnt, 0);
        run_to(m + 35);
        check("re_clr", entry_clear, 1);
        run_to(m + 70);
        check("re_clr_cnt", clr_cnt, 1);
        check("re_ev_cnt", ev_cnt, 2);

        // Reset during debounce after three mismatches
        do_reset();
        btn0_raw = 1'b1;
        n = e + 1;
        run_to(n + 4);
        reset    = 1'b1;
        btn0_raw = 1'b0;
        tick();
        reset = 1'b0;
        check("mid_rst_outs", {b0, b1, key_valid, entry_clear, busy}, 0);
        repeat (15) tick();
        check("mid_rst_no_ev", ev_cnt, 0);

        // Reset with the timer armed
        btn1_raw = 1'b1;
        n = e + 1;
        m = n + 6;
        run_to(n + 4);
        btn1_raw = 1'b0;
        run_to(m + 10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("arm_rst_outs", {b0, b1, key_valid, entry_clear, busy}, 0);
        run_to(m + 45);
        check("arm_rst_no_clr", clr_cnt, 0);
        check("arm_rst_ev", ev_cnt, 1);

        // Normal press after the resets
        btn0_raw = 1'b1;
        n = e + 1;
        run_to(n + 5);
        check("post_kv_early", key_valid, 0);
        run_to(n + 6);
        check("post_kv", key_valid, 1);
        check("post_b0", b0, 1);
        btn0_raw = 1'b0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
